// File: rtl/rc4_decrypt_core.sv
`default_nettype none
// rc4_decrypt_core: RC4 S-box init, key schedule and PRGA decryption of a MSG_LEN-byte
// ROM ciphertext into result RAM, aborting on the first byte outside {space, a..z}.
module rc4_decrypt_core #(
  parameter int MSG_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] sc_key,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wdata,
  output logic        s_we,
  input  logic [7:0]  s_rdata,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_rdata,
  output logic [7:0]  d_addr,
  output logic [7:0]  d_wdata,
  output logic        d_we,
  output logic        dc_done,
  output logic        dc_invalid,
  output logic        busy
);

  typedef enum logic [4:0] {
    IDLE, INIT,
    KSA_RD_I, KSA_WT_I, KSA_RD_J, KSA_WT_J, KSA_WR_I, KSA_WR_J,
    PR_INC, PR_RD_I, PR_WT_I, PR_RD_J, PR_WT_J, PR_WR_I, PR_WR_J,
    PR_RD_F, PR_WT_F, PR_XOR,
    DONE, INVALID
  } state_t;

  localparam logic [7:0] LAST_K = 8'(MSG_LEN - 1);

  state_t      state, state_n;
  logic [23:0] key, key_n;
  logic [7:0]  i, i_n, j, j_n, k, k_n, si, si_n, sj, sj_n;
  logic [1:0]  kidx, kidx_n, wcnt, wcnt_n;
  logic        p_ok, p_ok_n;
  logic [7:0]  s_addr_n, s_wdata_n, rom_addr_n, d_addr_n, d_wdata_n;
  logic        s_we_n, d_we_n, dc_done_n, dc_invalid_n, busy_n;
  logic [7:0]  key_byte, p;

  always_comb begin
    case (kidx)
      2'd0:    key_byte = key[23:16];
      2'd1:    key_byte = key[15:8];
      default: key_byte = key[7:0];
    endcase
  end

  assign p = s_rdata ^ rom_rdata;

  // Outputs are computed for the state being entered, so each registered
  // address/data/enable is on the bus during the state that names it.
  always_comb begin
    state_n    = state;
    key_n      = key;
    i_n        = i;
    j_n        = j;
    k_n        = k;
    si_n       = si;
    sj_n       = sj;
    kidx_n     = kidx;
    wcnt_n     = wcnt;
    p_ok_n     = p_ok;
    s_addr_n   = s_addr;
    s_wdata_n  = s_wdata;
    s_we_n     = 1'b0;
    rom_addr_n = rom_addr;
    d_addr_n   = d_addr;
    d_wdata_n  = d_wdata;
    d_we_n     = 1'b0;
    case (state)
      IDLE: if (start) begin
        key_n     = sc_key;
        i_n       = 8'd0;
        s_addr_n  = 8'd0;
        s_wdata_n = 8'd0;
        s_we_n    = 1'b1;
        state_n   = INIT;
      end
      INIT: if (i == 8'd255) begin
        i_n      = 8'd0;
        j_n      = 8'd0;
        kidx_n   = 2'd0;
        s_addr_n = 8'd0;
        state_n  = KSA_RD_I;
      end else begin
        i_n       = i + 8'd1;
        s_addr_n  = i + 8'd1;
        s_wdata_n = i + 8'd1;
        s_we_n    = 1'b1;
      end
      KSA_RD_I: state_n = KSA_WT_I;
      KSA_WT_I: begin
        si_n     = s_rdata;
        j_n      = j + s_rdata + key_byte;
        s_addr_n = j + s_rdata + key_byte;
        state_n  = KSA_RD_J;
      end
      KSA_RD_J: state_n = KSA_WT_J;
      KSA_WT_J, PR_WT_J: begin
        sj_n      = s_rdata;
        s_addr_n  = i;
        s_wdata_n = s_rdata;
        s_we_n    = 1'b1;
        state_n   = (state == KSA_WT_J) ? KSA_WR_I : PR_WR_I;
      end
      KSA_WR_I, PR_WR_I: begin
        s_addr_n  = j;
        s_wdata_n = si;
        s_we_n    = 1'b1;
        state_n   = (state == KSA_WR_I) ? KSA_WR_J : PR_WR_J;
      end
      KSA_WR_J: if (i == 8'd255) begin
        i_n     = 8'd0;
        j_n     = 8'd0;
        k_n     = 8'd0;
        state_n = PR_INC;
      end else begin
        i_n      = i + 8'd1;
        kidx_n   = (kidx == 2'd2) ? 2'd0 : kidx + 2'd1;
        s_addr_n = i + 8'd1;
        state_n  = KSA_RD_I;
      end
      PR_INC: begin
        i_n      = i + 8'd1;
        s_addr_n = i + 8'd1;
        state_n  = PR_RD_I;
      end
      PR_RD_I: state_n = PR_WT_I;
      PR_WT_I: begin
        si_n     = s_rdata;
        j_n      = j + s_rdata;
        s_addr_n = j + s_rdata;
        state_n  = PR_RD_J;
      end
      PR_RD_J: state_n = PR_WT_J;
      PR_WR_J: begin
        s_addr_n   = si + sj;
        rom_addr_n = k;
        state_n    = PR_RD_F;
      end
      PR_RD_F: begin
        wcnt_n  = 2'd0;
        state_n = PR_WT_F;
      end
      // Held three cycles so the byte period is the 12 cycles the key cycler expects.
      PR_WT_F: if (wcnt == 2'd2) begin
        p_ok_n    = (p == 8'h20) || (p >= 8'h61 && p <= 8'h7A);
        d_addr_n  = k;
        d_wdata_n = p;
        d_we_n    = (p == 8'h20) || (p >= 8'h61 && p <= 8'h7A);
        state_n   = PR_XOR;
      end else begin
        wcnt_n = wcnt + 2'd1;
      end
      PR_XOR: if (!p_ok) begin
        state_n = INVALID;
      end else if (k == LAST_K) begin
        state_n = DONE;
      end else begin
        k_n     = k + 8'd1;
        state_n = PR_INC;
      end
      DONE:    state_n = DONE;
      INVALID: state_n = INVALID;
      default: state_n = IDLE;
    endcase
    dc_done_n    = (state_n == DONE);
    dc_invalid_n = (state_n == INVALID);
    busy_n       = !(state_n == IDLE || state_n == DONE || state_n == INVALID);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      key        <= 24'd0;
      i          <= 8'd0;
      j          <= 8'd0;
      k          <= 8'd0;
      si         <= 8'd0;
      sj         <= 8'd0;
      kidx       <= 2'd0;
      wcnt       <= 2'd0;
      p_ok       <= 1'b0;
      s_addr     <= 8'd0;
      s_wdata    <= 8'd0;
      s_we       <= 1'b0;
      rom_addr   <= 8'd0;
      d_addr     <= 8'd0;
      d_wdata    <= 8'd0;
      d_we       <= 1'b0;
      dc_done    <= 1'b0;
      dc_invalid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      key        <= key_n;
      i          <= i_n;
      j          <= j_n;
      k          <= k_n;
      si         <= si_n;
      sj         <= sj_n;
      kidx       <= kidx_n;
      wcnt       <= wcnt_n;
      p_ok       <= p_ok_n;
      s_addr     <= s_addr_n;
      s_wdata    <= s_wdata_n;
      s_we       <= s_we_n;
      rom_addr   <= rom_addr_n;
      d_addr     <= d_addr_n;
      d_wdata    <= d_wdata_n;
      d_we       <= d_we_n;
      dc_done    <= dc_done_n;
      dc_invalid <= dc_invalid_n;
      busy       <= busy_n;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rc4_decrypt_core.sv
`default_nettype none
// tb_rc4_decrypt_core: RC4 decrypt core against an array-based RC4 model with
// randomized keys/plaintexts, alphabet boundaries, mid-run reset and start toggling.
module tb_rc4_decrypt_core;
  localparam int MSG_LEN  = 32;
  localparam int PR0      = 1 + 256 + 1536 + 1;      // cycle of first PR_INC
  localparam int XOR0     = PR0 + 11;                // cycle of first byte write
  localparam int DONE_CYC = 1 + 256 + 1536 + 12 * MSG_LEN + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [23:0] sc_key = 24'd0;
  logic [7:0] s_addr, s_wdata, rom_addr, d_addr, d_wdata;
  logic       s_we, d_we, dc_done, dc_invalid, busy;
  logic [7:0] s_rdata = 8'd0, rom_rdata = 8'd0;

  logic [7:0] sram [256];
  logic [7:0] rom  [256];
  logic [7:0] dram [256];
  logic [7:0] pt   [MSG_LEN];
  logic [7:0] m_s  [256];
  logic [7:0] m_ks [256];

  int total = 0, bad = 0;
  int cyc = 0, end_cyc = 0, nvalid = 0;
  bit run = 1'b0;

  rc4_decrypt_core #(.MSG_LEN(MSG_LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .sc_key(sc_key),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_rdata(s_rdata),
    .rom_addr(rom_addr), .rom_rdata(rom_rdata),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we),
    .dc_done(dc_done), .dc_invalid(dc_invalid), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous read-first memories.
  always @(posedge clk) begin
    s_rdata   <= sram[s_addr];
    rom_rdata <= rom[rom_addr];
    if (s_we) sram[s_addr] = s_wdata;
    if (d_we) dram[d_addr] = d_wdata;
    if (run) cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_ok(input logic [7:0] b);
    return (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
  endfunction

  function automatic logic [7:0] rand_char();
    int r = $urandom_range(0, 26);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  // Plain RC4: KSA then nsteps PRGA steps; leaves S in m_s and keystream in m_ks.
  task automatic rc4_model(input logic [23:0] key, input int nsteps);
    logic [7:0] s [256];
    logic [7:0] kb [3];
    logic [7:0] t;
    int jj, ii;
    kb[0] = key[23:16]; kb[1] = key[15:8]; kb[2] = key[7:0];
    for (int x = 0; x < 256; x++) s[x] = 8'(x);
    jj = 0;
    for (int x = 0; x < 256; x++) begin
      jj = (jj + s[x] + kb[x % 3]) % 256;
      t = s[x]; s[x] = s[jj]; s[jj] = t;
    end
    ii = 0; jj = 0;
    for (int n = 0; n < nsteps; n++) begin
      ii = (ii + 1) % 256;
      jj = (jj + s[ii]) % 256;
      t = s[ii]; s[ii] = s[jj]; s[jj] = t;
      m_ks[n] = s[(32'(s[ii]) + 32'(s[jj])) % 256];
    end
    for (int x = 0; x < 256; x++) m_s[x] = s[x];
  endtask

  task automatic set_pt_str(input logic [255:0] str, input int len);
    for (int n = 0; n < len; n++) pt[n] = str[8*(len-1-n) +: 8];
  endtask

  task automatic fill_pt(input logic [7:0] c);
    for (int n = 0; n < MSG_LEN; n++) pt[n] = c;
  endtask

  task automatic rand_pt();
    for (int n = 0; n < MSG_LEN; n++) pt[n] = rand_char();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("reset_outs", {s_addr, s_wdata, s_we, rom_addr, d_addr, d_wdata, d_we,
                       dc_done, dc_invalid, busy}, 64'd0);
  endtask

  // Per-cycle comparison against the cycle-exact expectations of the current run.
  always @(negedge clk) begin
    if (run) begin
      bit exp_we;
      int kk;
      if (cyc >= 2 && cyc <= 257) begin
        chk("init_we", s_we, 1);
        chk("init_addr", s_addr, cyc - 2);
        chk("init_data", s_wdata, cyc - 2);
      end
      chk("busy", busy, (cyc >= 2 && cyc < end_cyc));
      chk("dc_done", dc_done, (cyc >= end_cyc && nvalid == MSG_LEN));
      chk("dc_invalid", dc_invalid, (cyc >= end_cyc && nvalid < MSG_LEN));
      kk = (cyc - XOR0) / 12;
      exp_we = (cyc >= XOR0) && ((cyc - XOR0) % 12 == 0) && (kk < nvalid);
      chk("d_we", d_we, exp_we);
      if (d_we && exp_we) begin
        chk("d_addr", d_addr, kk);
        chk("d_wdata", d_wdata, pt[kk]);
      end
    end
  end

  task automatic run_case(input logic [23:0] key, input int abort_at, input bit tog);
    int mism;
    do_reset();
    rc4_model(key, MSG_LEN);
    nvalid = MSG_LEN;
    for (int n = MSG_LEN - 1; n >= 0; n--) if (!is_ok(pt[n])) nvalid = n;
    end_cyc = (nvalid == MSG_LEN) ? DONE_CYC : PR0 + 12 * nvalid + 12;
    for (int n = 0; n < 256; n++) begin
      rom[n]  = (n < MSG_LEN) ? (pt[n] ^ m_ks[n]) : 8'h00;
      dram[n] = 8'hEE;
    end
    sc_key = key;
    start  = 1'b1;
    cyc    = 1;
    run    = 1'b1;
    while (cyc < end_cyc + 4) begin
      @(negedge clk);
      if (tog) start = 1'($urandom_range(0, 1));
      if (abort_at > 0 && cyc == abort_at) begin
        run   = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_outs", {s_addr, s_wdata, s_we, rom_addr, d_addr, d_wdata, d_we,
                           dc_done, dc_invalid, busy}, 64'd0);
        @(posedge clk); #1;
        chk("abort_next", {s_addr, s_wdata, s_we, rom_addr, d_addr, d_wdata, d_we,
                           dc_done, dc_invalid, busy}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        return;
      end
    end
    run   = 1'b0;
    start = 1'b0;
    for (int n = 0; n < MSG_LEN; n++)
      chk("dram", dram[n], (n < nvalid) ? pt[n] : 8'hEE);
    rc4_model(key, (nvalid == MSG_LEN) ? MSG_LEN : nvalid + 1);
    mism = 0;
    for (int x = 0; x < 256; x++) if (sram[x] !== m_s[x]) mism++;
    chk("sbox_final", mism, 0);
  endtask

  initial begin
    logic [71:0] lit_ks, lit_ct;
    logic [7:0]  v;
    logic [7:0]  bvals [6];
    int pos;

    // Published RC4 vector: key "Key", plaintext "Plaintext".
    lit_ks = 72'hEB9F7781B734CA72A7;
    lit_ct = 72'h9BF316E8D940AF0AD3;   // same vector with 'P' lowered to 'p'
    rc4_model(24'h4B6579, MSG_LEN);
    for (int n = 0; n < 9; n++) chk("model_ks_lit", m_ks[n], lit_ks[8*(8-n) +: 8]);

    // Scenario: key 0 (i==j at KSA i=0), all 'a'.
    fill_pt(8'h61);
    run_case(24'h000000, 0, 1'b0);
    chk("s1_d0", dram[0], 8'h61);
    chk("s1_d31", dram[31], 8'h61);

    // Known sentence, then with an 'A' at byte 5.
    set_pt_str("the quick brown fox jumps over a", 32);
    run_case(24'h123456, 0, 1'b0);
    chk("s2_d4", dram[4], 8'h71);
    pt[5] = 8'h41;
    run_case(24'h123456, 0, 1'b0);
    chk("s3_d4", dram[4], 8'h71);
    chk("s3_d5", dram[5], 8'hEE);

    // Alphabet boundaries at byte 0.
    bvals[0] = 8'h20; bvals[1] = 8'h61; bvals[2] = 8'h7A;
    bvals[3] = 8'h1F; bvals[4] = 8'h60; bvals[5] = 8'h7B;
    for (int b = 0; b < 6; b++) begin
      fill_pt(8'h61);
      pt[0] = bvals[b];
      run_case(24'($urandom), 0, 1'b0);
    end

    // Reset during KSA, then a clean rerun with key 0.
    fill_pt(8'h61);
    run_case(24'h000000, 800, 1'b0);
    run_case(24'h000000, 0, 1'b0);

    // start toggled while busy, then reset clears status.
    set_pt_str("the quick brown fox jumps over a", 32);
    run_case(24'h123456, 0, 1'b1);
    do_reset();

    // Literal ciphertext pin: DUT must recover "plaintext".
    rand_pt();
    set_pt_str("plaintext", 9);
    rc4_model(24'h4B6579, MSG_LEN);
    for (int n = 0; n < 9; n++) chk("model_ct_lit", pt[n] ^ m_ks[n], lit_ct[8*(8-n) +: 8]);
    run_case(24'h4B6579, 0, 1'b0);
    chk("lit_d0", dram[0], 8'h70);
    chk("lit_d8", dram[8], 8'h74);

    // Randomized keys and texts, some with one out-of-alphabet byte.
    for (int r = 0; r < 5; r++) begin
      rand_pt();
      if (r >= 3) begin
        do v = 8'($urandom); while (is_ok(v));
        pos = $urandom_range(0, MSG_LEN - 1);
        pt[pos] = v;
      end
      run_case(24'($urandom), 0, 1'(r % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
